dvp_pattern_source: RTL and testbench
=====================================

# dvp_pattern_source

Transmit end of the OV5642 Digital Video Port: emits a DVP stream (vsync, href, 8-bit pixel data) carrying an RGB565 colour-bar test image, byte-serialised high byte first. Serves as a sensor stand-in for bring-up and loopback of the DVP receive / pixel-buffer / HDMI path without the camera fitted, and as the stimulus source in that path's benches. All outputs are registered and change on the rising edge of `i_clk`; the receiver uses the same clock as its pixel clock.

## Interface
- `H_ACTIVE`, 1280, active pixels per line; must be a multiple of 8
- `H_BLANK`, 256, href-low cycles at the end of every line; must be ≥ 1
- `V_ACTIVE`, 720, active lines per frame
- `VSYNC_LINES`, 4, lines with vsync high
- `V_BACK`, 16, idle lines after vsync
- `V_FRONT`, 8, idle lines after the last active line
- `i_clk`  in  1  pixel clock, rising-edge
- `i_rst`  in  1  asynchronous, active-high reset
- `i_en`  in  1  frame-generation enable, level
- `o_dvp_vsync`  out  1  frame sync, active high
- `o_dvp_href`  out  1  line valid, active high
- `o_dvp_pdata`  out  8  pixel byte; forced to 0 whenever href is low
- `o_frame_done`  out  1  one-cycle pulse on the last cycle of each frame
- `o_frame_cnt`  out  16  completed-frame count, wraps at 16'hFFFF→0

## Operation
- Line length is L = 2·H_ACTIVE + H_BLANK cycles for every line, including vsync and idle lines.
- Frame length is VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT lines.
- State machine: IDLE → VSYNC → VBACK → ACTIVE → VFRONT.
  - From VFRONT, go to VSYNC if `i_en` = 1; otherwise go to IDLE.
  - Each non-IDLE state exits on the last cycle of its final line.
  - IDLE → VSYNC when `i_en` is sampled high.
- VSYNC: `o_dvp_vsync` = 1 for all of its cycles; href = 0.
- ACTIVE line: href = 1 for cycles 0..2·H_ACTIVE−1 of the line, then 0 for H_BLANK cycles.
- Byte order: pixel x occupies byte pair 2x (bits [15:8]) then 2x+1 (bits [7:0]).
- Colour bars: bar index is x / (H_ACTIVE/8). Bars 0..7 are 16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000.
- Counters: pixel/byte counter, line counter, state register. All counter widths are sized with `$clog2` from the parameters.
- Dropping `i_en` mid-frame does not truncate the frame; the frame completes and the block returns to IDLE.
- `o_frame_done` pulses on the final VFRONT cycle. `o_frame_cnt` increments on that same edge, so the new value is visible one cycle later.

## Timing
- Reset values: every output 0; state IDLE; all counters 0. Reset asserted mid-frame clears all outputs immediately, without waiting for a clock.
- Start latency: `i_en` sampled high in IDLE at edge k → `o_dvp_vsync` = 1 from edge k+1.
- First href rises (VSYNC_LINES + V_BACK)·L cycles after vsync rises.
- Back-to-back frames: with `i_en` held high, VSYNC follows VFRONT with no gap.
- Frame period is exactly (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT)·L cycles.
- `o_dvp_pdata` is valid on exactly the cycles where href = 1.
- vsync and href are never high in the same cycle.

## Configuration
- `DVP_SRC_SCROLL_EN` defined: the pattern scrolls left one pixel per frame.
  - Pattern pixel = (x + o_frame_cnt) mod H_ACTIVE; modulo computed over `o_frame_cnt`'s low bits widened to the x width.
  - The offset is latched at VSYNC entry and held constant for the whole frame.
- Macro undefined: offset is 0 and the pattern is static. No offset register is synthesised.

## Structure
- Shared package `dvp_src_pkg` holds:
  - the state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT)
  - the eight RGB565 bar constants
  - the pixel-to-bar-index function
- Sub-module `dvp_timing_gen` holds the byte/line counters and state machine. It outputs vsync, href, x and last-cycle flags.
- The top level adds the pattern lookup, byte select, frame counter and output registers.

## Test plan
Bench parameters: H_ACTIVE=16, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_ACTIVE=4, V_FRONT=1, giving L = 36 and a frame of 252 cycles.
- Reset then hold `i_en` = 0 for 500 cycles → all outputs stay 0.
- `i_en` high at edge k → vsync high on edges k+1..k+36, then low. href first rises 72 cycles after vsync rises.
- Capture one active line → 32 bytes FF,FF,FF,FF,FF,E0,FF,E0,07,FF,…,00,00 (each bar 2 pixels), then 4 href-low cycles with pdata = 0.
- `i_en` held high for 3 frames:
  - vsync period is exactly 252 cycles
  - `o_frame_done` pulses 3 times
  - `o_frame_cnt` reads 3
  - With `DVP_SRC_SCROLL_EN` defined, frame 1 line starts at pixel 1: bytes FF,FF,FF,E0.
- Drop `i_en` at cycle 100 of a frame → that frame completes at 252 cycles, then the block sits in IDLE with no further vsync.
- Assert `i_rst` mid-line with href high → href, vsync and pdata are 0 before the next clock edge. After release and `i_en` high, a full frame replays from VSYNC.

Source files
------------

// File: rtl/dvp_src_pkg.sv
// rtl/dvp_src_pkg.sv - shared types, colour-bar constants and helpers for the DVP pattern source
//
// Purpose : state enum for the frame sequencer, the eight RGB565 bar colours,
//           and the pixel-to-bar lookup used by the top level.
// Ports   : none (package).

package dvp_src_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  localparam logic [15:0] BAR_0 = 16'hFFFF;  // white
  localparam logic [15:0] BAR_1 = 16'hFFE0;  // yellow
  localparam logic [15:0] BAR_2 = 16'h07FF;  // cyan
  localparam logic [15:0] BAR_3 = 16'h07E0;  // green
  localparam logic [15:0] BAR_4 = 16'hF81F;  // magenta
  localparam logic [15:0] BAR_5 = 16'hF800;  // red
  localparam logic [15:0] BAR_6 = 16'h001F;  // blue
  localparam logic [15:0] BAR_7 = 16'h0000;  // black

  // Eight equal-width bars across the active line.
  function automatic logic [2:0] bar_index(input int unsigned x, input int unsigned h_active);
    return 3'(x / (h_active / 8));
  endfunction

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_0;
      3'd1:    c = BAR_1;
      3'd2:    c = BAR_2;
      3'd3:    c = BAR_3;
      3'd4:    c = BAR_4;
      3'd5:    c = BAR_5;
      3'd6:    c = BAR_6;
      default: c = BAR_7;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_pattern_source_timing.sv
// rtl/dvp_pattern_source_timing.sv - byte/line counters and frame state machine (module dvp_timing_gen)
//
// Purpose : walks IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT, every line being
//           2*H_ACTIVE + H_BLANK cycles long. All outputs are combinational
//           from the counters; the top level registers them.
// Ports   : clk, rst (async, active high), en (frame enable, level)
//           vsync       - in VSYNC state
//           href        - active byte slot of an ACTIVE line
//           x           - pixel index of the current byte pair
//           byte_lo     - second (low) byte of the pixel
//           frame_last  - last cycle of the frame (final VFRONT cycle)
//           frame_start - this edge enters VSYNC

module dvp_timing_gen
  import dvp_src_pkg::*;
#(
  parameter int H_ACTIVE    = 1280,
  parameter int H_BLANK     = 256,
  parameter int V_ACTIVE    = 720,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 8,
  localparam int XW         = $clog2(H_ACTIVE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          vsync,
  output logic          href,
  output logic [XW-1:0] x,
  output logic          byte_lo,
  output logic          frame_last,
  output logic          frame_start
);

  localparam int L    = 2 * H_ACTIVE + H_BLANK;
  localparam int CW   = $clog2(L);
  localparam int M1   = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int M2   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAXL = (M1 > M2) ? M1 : M2;
  localparam int LW   = $clog2(MAXL + 1);

  state_t          state, state_next;
  logic [CW-1:0]   col;
  logic [LW-1:0]   line;
  logic [LW-1:0]   lines_m1;
  logic            line_last;
  logic            state_last;

  always_comb begin
    lines_m1 = '0;
    case (state)
      ST_VSYNC:  lines_m1 = LW'(VSYNC_LINES - 1);
      ST_VBACK:  lines_m1 = LW'(V_BACK - 1);
      ST_ACTIVE: lines_m1 = LW'(V_ACTIVE - 1);
      ST_VFRONT: lines_m1 = LW'(V_FRONT - 1);
      default:   lines_m1 = '0;
    endcase
  end

  assign line_last  = (state != ST_IDLE) && (col == CW'(L - 1));
  assign state_last = line_last && (line == lines_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (en)         state_next = ST_VSYNC;
      ST_VSYNC:  if (state_last) state_next = ST_VBACK;
      ST_VBACK:  if (state_last) state_next = ST_ACTIVE;
      ST_ACTIVE: if (state_last) state_next = ST_VFRONT;
      // Enable is only looked at here, so a dropped enable never cuts a frame short.
      ST_VFRONT: if (state_last) state_next = en ? ST_VSYNC : ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      line <= '0;
    end else if (state == ST_IDLE) begin
      col  <= '0;
      line <= '0;
    end else if (line_last) begin
      col  <= '0;
      line <= (line == lines_m1) ? '0 : line + LW'(1);
    end else begin
      col  <= col + CW'(1);
    end
  end

  assign vsync       = (state == ST_VSYNC);
  assign href        = (state == ST_ACTIVE) && (col < CW'(2 * H_ACTIVE));
  assign x           = col[XW:1];
  assign byte_lo     = col[0];
  assign frame_last  = (state == ST_VFRONT) && state_last;
  assign frame_start = (state_next == ST_VSYNC) && (state != ST_VSYNC);

endmodule

// File: rtl/dvp_pattern_source.sv
// rtl/dvp_pattern_source.sv - DVP transmitter emitting an RGB565 colour-bar test image
//
// Purpose : sensor stand-in for the DVP receive path. Bytes are sent high byte
//           first; all outputs are registered on i_clk.
// Config  : DVP_SRC_SCROLL_EN - pattern scrolls left one pixel per frame.
// Ports   : i_clk        pixel clock
//           i_rst        async active-high reset
//           i_en         frame-generation enable (level)
//           o_dvp_vsync  frame sync
//           o_dvp_href   line valid
//           o_dvp_pdata  pixel byte, 0 while href is low
//           o_frame_done one-cycle pulse on the last cycle of each frame
//           o_frame_cnt  completed-frame count (wraps)

module dvp_pattern_source
  import dvp_src_pkg::*;
#(
  parameter int H_ACTIVE    = 1280,
  parameter int H_BLANK     = 256,
  parameter int V_ACTIVE    = 720,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic        o_dvp_vsync,
  output logic        o_dvp_href,
  output logic [7:0]  o_dvp_pdata,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt
);

  localparam int XW = $clog2(H_ACTIVE);

  logic          tg_vsync;
  logic          tg_href;
  logic [XW-1:0] tg_x;
  logic          tg_byte_lo;
  logic          tg_frame_last;
  logic          tg_frame_start;
  logic [XW-1:0] pix_x;
  logic [15:0]   color;
  logic [7:0]    pdata_next;

  dvp_timing_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .H_BLANK     (H_BLANK),
    .V_ACTIVE    (V_ACTIVE),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) u_timing (
    .clk         (i_clk),
    .rst         (i_rst),
    .en          (i_en),
    .vsync       (tg_vsync),
    .href        (tg_href),
    .x           (tg_x),
    .byte_lo     (tg_byte_lo),
    .frame_last  (tg_frame_last),
    .frame_start (tg_frame_start)
  );

`ifdef DVP_SRC_SCROLL_EN
  logic [XW-1:0] offset;
  logic [XW:0]   pix_sum;

  // The frame counter bump lags frame_done by one edge, so fold in a pending
  // increment (either the one being signalled now or the one still in flight)
  // to latch the count of frames completed before this one starts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               offset <= '0;
    else if (tg_frame_start) offset <= o_frame_cnt[XW-1:0] + XW'(tg_frame_last) + XW'(o_frame_done);
  end

  assign pix_sum = {1'b0, tg_x} + {1'b0, offset};
  assign pix_x   = XW'(pix_sum % (XW + 1)'(H_ACTIVE));
`else
  logic unused_frame_start;
  assign unused_frame_start = tg_frame_start;
  assign pix_x              = tg_x;
`endif

  assign color      = bar_color(bar_index(32'(pix_x), 32'(H_ACTIVE)));
  assign pdata_next = tg_byte_lo ? color[7:0] : color[15:8];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dvp_vsync  <= 1'b0;
      o_dvp_href   <= 1'b0;
      o_dvp_pdata  <= 8'h00;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= 16'h0000;
    end else begin
      o_dvp_vsync  <= tg_vsync;
      o_dvp_href   <= tg_href;
      o_dvp_pdata  <= tg_href ? pdata_next : 8'h00;
      o_frame_done <= tg_frame_last;
      o_frame_cnt  <= o_frame_cnt + 16'(o_frame_done);
    end
  end

endmodule

// File: tb/tb_dvp_pattern_source.sv
// tb/tb_dvp_pattern_source.sv - self-checking bench for dvp_pattern_source

module tb_dvp_pattern_source;

  localparam int HA    = 16;
  localparam int HB    = 4;
  localparam int VS    = 1;
  localparam int VB    = 1;
  localparam int VA    = 4;
  localparam int VF    = 1;
  localparam int L     = 2 * HA + HB;
  localparam int FRAME = (VS + VB + VA + VF) * L;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en  = 1'b0;
  logic        o_dvp_vsync;
  logic        o_dvp_href;
  logic [7:0]  o_dvp_pdata;
  logic        o_frame_done;
  logic [15:0] o_frame_cnt;

  int tests = 0;
  int fails = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [7:0] line_exp [32] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'hFF, 8'hE0,
                                8'h07, 8'hFF, 8'h07, 8'hFF, 8'h07, 8'hE0, 8'h07, 8'hE0,
                                8'hF8, 8'h1F, 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'hF8, 8'h00,
                                8'h00, 8'h1F, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00};

  dvp_pattern_source #(
    .H_ACTIVE    (HA),
    .H_BLANK     (HB),
    .V_ACTIVE    (VA),
    .VSYNC_LINES (VS),
    .V_BACK      (VB),
    .V_FRONT     (VF)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .o_dvp_vsync  (o_dvp_vsync),
    .o_dvp_href   (o_dvp_href),
    .o_dvp_pdata  (o_dvp_pdata),
    .o_frame_done (o_frame_done),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Expected {vsync, href, pdata, frame_done, frame_cnt} at cycle t of a frame
  // during which cnt frames have already completed.
  function automatic logic [26:0] ref_out(input int t, input int cnt);
    int ln, col, x, px;
    logic vs, hr, dn;
    logic [7:0] pd;
    logic [15:0] c;
    ln  = t / L;
    col = t % L;
    vs  = (ln < VS);
    hr  = (ln >= VS + VB) && (ln < VS + VB + VA) && (col < 2 * HA);
    pd  = 8'h00;
    if (hr) begin
      x  = col / 2;
      px = x;
`ifdef DVP_SRC_SCROLL_EN
      px = (x + cnt) % HA;
`endif
      c  = bars[px / (HA / 8)];
      pd = (col % 2 == 1) ? c[7:0] : c[15:8];
    end
    dn = (t == FRAME - 1);
    return {vs, hr, pd, dn, 16'(cnt)};
  endfunction

  function automatic logic [26:0] obs();
    return {o_dvp_vsync, o_dvp_href, o_dvp_pdata, o_frame_done, o_frame_cnt};
  endfunction

  function automatic logic [26:0] idle_out(input int cnt);
    return {1'b0, 1'b0, 8'h00, 1'b0, 16'(cnt)};
  endfunction

  task automatic test_reset();
    i_rst = 1'b1;
    i_en  = 1'b0;
    repeat (3) @(negedge i_clk);
    tests++;
    if (obs() !== idle_out(0)) begin
      fails++;
      $display("FAIL reset_state got %h want %h", obs(), idle_out(0));
    end
    i_rst = 1'b0;
  endtask

  task automatic test_idle_hold();
    int bad = 0;
    logic [26:0] first_bad = '0;
    for (int i = 0; i < 500; i++) begin
      @(negedge i_clk);
      if (obs() !== idle_out(0)) begin
        if (bad == 0) first_bad = obs();
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_hold bad_cycles=%0d first %h want %h", bad, first_bad, idle_out(0));
    end
  endtask

  task automatic test_first_frame();
    int vs_cnt = 0;
    int href_first = -1;
    logic [7:0] cap [36];
    repeat ($urandom_range(0, 15)) @(negedge i_clk);
    i_en = 1'b1;
    @(negedge i_clk);
    i_en = 1'b0;
    tests++;
    if (obs() !== idle_out(0)) begin
      fails++;
      $display("FAIL start_not_early got %h want %h", obs(), idle_out(0));
    end
    for (int t = 0; t < FRAME; t++) begin
      @(negedge i_clk);
      tests++;
      if (obs() !== ref_out(t, 0)) begin
        fails++;
        $display("FAIL first_frame t=%0d got %h want %h", t, obs(), ref_out(t, 0));
      end
      if (o_dvp_vsync) vs_cnt++;
      if (o_dvp_href && href_first < 0) href_first = t;
      if (t >= (VS + VB) * L && t < (VS + VB + 1) * L) cap[t - (VS + VB) * L] = o_dvp_pdata;
    end
    tests++;
    if (vs_cnt != VS * L) begin
      fails++;
      $display("FAIL vsync_width got %0d want %0d", vs_cnt, VS * L);
    end
    tests++;
    if (href_first != (VS + VB) * L) begin
      fails++;
      $display("FAIL href_first got %0d want %0d", href_first, (VS + VB) * L);
    end
    for (int b = 0; b < 36; b++) begin
      tests++;
      if (cap[b] !== ((b < 32) ? line_exp[b] : 8'h00)) begin
        fails++;
        $display("FAIL line_byte b=%0d got %h want %h", b, cap[b], (b < 32) ? line_exp[b] : 8'h00);
      end
    end
    @(negedge i_clk);
    tests++;
    if (obs() !== idle_out(1)) begin
      fails++;
      $display("FAIL first_frame_end got %h want %h", obs(), idle_out(1));
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int rise [3];
    int nrise = 0;
    int cyc = 0;
    logic prev_vs = 1'b0;
    logic [7:0] f1 [4];
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat ($urandom_range(0, 15)) @(negedge i_clk);
    i_en = 1'b1;
    @(negedge i_clk);
    for (int f = 0; f < 3; f++) begin
      for (int t = 0; t < FRAME; t++) begin
        @(negedge i_clk);
        if (f == 2 && t == 0) i_en = 1'b0;
        tests++;
        if (obs() !== ref_out(t, f)) begin
          fails++;
          $display("FAIL b2b f=%0d t=%0d got %h want %h", f, t, obs(), ref_out(t, f));
        end
        if (o_frame_done) done_cnt++;
        if (o_dvp_vsync && !prev_vs && nrise < 3) begin
          rise[nrise] = cyc;
          nrise++;
        end
        prev_vs = o_dvp_vsync;
        if (f == 1 && t >= (VS + VB) * L && t < (VS + VB) * L + 4) f1[t - (VS + VB) * L] = o_dvp_pdata;
        cyc++;
      end
    end
    @(negedge i_clk);
    tests++;
    if (done_cnt != 3) begin
      fails++;
      $display("FAIL done_pulses got %0d want 3", done_cnt);
    end
    tests++;
    if (o_frame_cnt !== 16'd3) begin
      fails++;
      $display("FAIL frame_cnt got %0d want 3", o_frame_cnt);
    end
    tests++;
    if (nrise != 3) begin
      fails++;
      $display("FAIL vsync_rises got %0d want 3", nrise);
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (rise[i] - rise[i - 1] != FRAME) begin
          fails++;
          $display("FAIL vsync_period i=%0d got %0d want %0d", i, rise[i] - rise[i - 1], FRAME);
        end
      end
    end
`ifdef DVP_SRC_SCROLL_EN
    tests++;
    if ({f1[0], f1[1], f1[2], f1[3]} !== 32'hFFFFFFE0) begin
      fails++;
      $display("FAIL scroll_f1 got %h want FFFFFFE0", {f1[0], f1[1], f1[2], f1[3]});
    end
`else
    tests++;
    if ({f1[0], f1[1], f1[2], f1[3]} !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL static_f1 got %h want FFFFFFFF", {f1[0], f1[1], f1[2], f1[3]});
    end
`endif
  endtask

  task automatic test_drop_enable();
    int vs_seen = 0;
    int bad = 0;
    i_en = 1'b1;
    @(negedge i_clk);
    for (int t = 0; t < FRAME; t++) begin
      @(negedge i_clk);
      if (t == 100) i_en = 1'b0;
      tests++;
      if (obs() !== ref_out(t, 3)) begin
        fails++;
        $display("FAIL drop_en t=%0d got %h want %h", t, obs(), ref_out(t, 3));
      end
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (o_dvp_vsync) vs_seen++;
      if (obs() !== idle_out(4)) bad++;
    end
    tests++;
    if (vs_seen != 0 || bad != 0) begin
      fails++;
      $display("FAIL drop_en_idle vsync_cycles=%0d bad_cycles=%0d got %h want %h", vs_seen, bad, obs(), idle_out(4));
    end
  endtask

  task automatic test_reset_midline();
    int stop_t;
    stop_t = (VS + VB) * L + int'($urandom_range(0, 2 * HA - 1));
    i_en = 1'b1;
    @(negedge i_clk);
    for (int t = 0; t <= stop_t; t++) begin
      @(negedge i_clk);
      tests++;
      if (obs() !== ref_out(t, 4)) begin
        fails++;
        $display("FAIL pre_reset t=%0d got %h want %h", t, obs(), ref_out(t, 4));
      end
    end
    #2 i_rst = 1'b1;
    #1;
    tests++;
    if (obs() !== idle_out(0)) begin
      fails++;
      $display("FAIL async_reset got %h want %h", obs(), idle_out(0));
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    i_en  = 1'b1;
    @(negedge i_clk);
    i_en  = 1'b0;
    for (int t = 0; t < FRAME; t++) begin
      @(negedge i_clk);
      tests++;
      if (obs() !== ref_out(t, 0)) begin
        fails++;
        $display("FAIL replay t=%0d got %h want %h", t, obs(), ref_out(t, 0));
      end
    end
    @(negedge i_clk);
    tests++;
    if (obs() !== idle_out(1)) begin
      fails++;
      $display("FAIL replay_end got %h want %h", obs(), idle_out(1));
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_first_frame();
    test_back_to_back();
    test_drop_enable();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
